// File: rtl/mvm3_pkg.sv
// Shared constants and types for the 3x3 signed matrix-vector multiplier.
package mvm3_pkg;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = 18;
  localparam int N      = 3;
  localparam int NUM_IN = 12;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  typedef logic signed [IN_W-1:0]  elem_t;
  typedef logic signed [OUT_W-1:0] res_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_MAX = acc_t'(2**(OUT_W-1) - 1);
  localparam acc_t ACC_MIN = acc_t'(-(2**(OUT_W-1)));
  localparam res_t RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam res_t RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};
endpackage

// File: rtl/mvm3_mac.sv
// Signed multiply-accumulate with range check on the running sum.
// Build option MVM3_SATURATE_EN clamps out-of-range results instead of wrapping.
module mvm3_mac
  import mvm3_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  input  elem_t a,
  input  elem_t b,
  output res_t  res,
  output logic  ovf
);
  acc_t acc, prod, sum;

  assign prod = acc_t'(a) * acc_t'(b);
  // clr starts a fresh row: the first term replaces whatever is left in acc
  assign sum  = (clr ? acc_t'(0) : acc) + prod;
  assign ovf  = (sum > ACC_MAX) || (sum < ACC_MIN);

`ifdef MVM3_SATURATE_EN
  assign res = ovf ? (sum[ACC_W-1] ? RES_MIN : RES_MAX) : sum[OUT_W-1:0];
`else
  assign res = sum[OUT_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/mvm3_part1.sv
// Streaming 3x3 signed matrix-vector multiply: load 12 words, emit y[0..2].
// Optional MVM3_SATURATE_EN (in mvm3_mac) saturates out-of-range results.
module mvm3_part1
  import mvm3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             overflow
);
  state_t     state;
  logic [3:0] cnt;
  logic [1:0] row, k;
  elem_t      a_mem [N*N];
  elem_t      x_mem [N];
  logic [3:0] a_idx;
  res_t       mac_res;
  logic       mac_ovf;

  assign a_idx = 4'(row) * 4'd3 + 4'(k);

  mvm3_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (state == COMPUTE),
    .clr   (k == 2'd0),
    .a     (a_mem[a_idx]),
    .b     (x_mem[k]),
    .res   (mac_res),
    .ovf   (mac_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      cnt      <= '0;
      row      <= '0;
      k        <= '0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      data_out <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N*N; i++) a_mem[i] <= '0;
      for (int i = 0; i < N; i++)   x_mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            if (cnt < 4'd9) a_mem[cnt] <= elem_t'(data_in);
            else            x_mem[2'(cnt - 4'd9)] <= elem_t'(data_in);
            if (cnt == 4'(NUM_IN-1)) begin
              state   <= COMPUTE;
              cnt     <= '0;
              row     <= '0;
              k       <= '0;
              s_ready <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        COMPUTE: begin
          if (k == 2'd2) begin
            data_out <= mac_res;
            overflow <= mac_ovf;
            m_valid  <= 1'b1;
            k        <= '0;
            state    <= OUTPUT;
          end else begin
            k <= k + 2'd1;
          end
        end
        OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (row == 2'd2) begin
              row     <= '0;
              s_ready <= 1'b1;
              state   <= LOAD;
            end else begin
              row   <= row + 2'd1;
              state <= COMPUTE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm3_part1.sv
// Directed bench for mvm3_part1: hand-computed y = A*x vectors with stalls and resets.
module tb_mvm3_part1;
  logic        clk = 0;
  logic        reset = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [7:0]  data_in = '0;
  logic        m_valid;
  logic        m_ready = 0;
  logic [15:0] data_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  mvm3_part1 dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_word(input int v, input int gap);
    int n;
    s_valid = 0;
    data_in = 'x;
    repeat (gap) @(negedge clk);
    s_valid = 1;
    data_in = 8'(v);
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 0;
    data_in = 'x;
  endtask

  task automatic send_set(input int v[12], input int maxgap);
    for (int i = 0; i < 12; i++) send_word(v[i], $urandom_range(0, maxgap));
  endtask

  task automatic recv(input string tag, input int ey, input int eo, input int maxstall);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) check({tag, "_timeout"}, 0, 1);
    repeat ($urandom_range(0, maxstall)) @(negedge clk);
    @(negedge clk);
    check({tag, "_y"}, int'($signed(data_out)), ey);
    check({tag, "_ovf"}, int'(overflow), eo);
    m_ready = 1;
    @(posedge clk);
    #1;
    m_ready = 0;
  endtask

  int set1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3};
  int set2[12] = '{1, 2, 3, 127, 127, 127, 7, 8, 9, 127, 127, 127};
  int set3[12] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
  int set4[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 5, -6, 7};
`ifdef MVM3_SATURATE_EN
  localparam int Y2_1 = 32767;
  localparam int Y3   = 32767;
`else
  localparam int Y2_1 = -17149;
  localparam int Y3   = -16384;
`endif

  initial begin
    logic [15:0] d0;
    logic        o0;
    logic        stable;

    // reset state
    #2;
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    check("load_s_ready", int'(s_ready), 1);

    // basic set with latency check
    send_set(set1, 2);
    check("acc_s_ready_low", int'(s_ready), 0);
    check("lat0_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    check("lat1_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    check("lat2_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    check("lat3_m_valid", int'(m_valid), 1);
    recv("s1r0", 14, 0, 3);
    recv("s1r1", 32, 0, 3);
    recv("s1r2", 50, 0, 3);

    // overflow in the middle row only
    send_set(set2, 1);
    recv("s2r0", 762, 0, 2);
    recv("s2r1", Y2_1, 1, 2);
    recv("s2r2", 3048, 0, 2);

    // most negative inputs everywhere
    send_set(set3, 1);
    recv("s3r0", Y3, 1, 1);
    recv("s3r1", Y3, 1, 1);
    recv("s3r2", Y3, 1, 1);

    // long downstream stall
    send_set(set1, 0);
    while (!m_valid) @(negedge clk);
    d0 = data_out;
    o0 = overflow;
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (data_out !== d0 || overflow !== o0 || m_valid !== 1'b1 || s_ready !== 1'b0) stable = 0;
    end
    check("stall_stable", int'(stable), 1);
    check("stall_y", int'($signed(d0)), 14);
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0;
    check("stall_single_xfer", int'(m_valid), 0);
    recv("stall_r1", 32, 0, 0);
    recv("stall_r2", 50, 0, 0);

    // reset after 7 accepted words
    for (int i = 0; i < 7; i++) send_word(9 - i, 0);
    reset = 0;
    #1;
    check("midrst_s_ready", int'(s_ready), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    @(negedge clk);
    reset = 1;
    send_set(set1, 1);
    recv("rst_r0", 14, 0, 1);
    recv("rst_r1", 32, 0, 1);
    recv("rst_r2", 50, 0, 1);

    // back-to-back sets
    send_set(set1, 0);
    recv("b2b_a0", 14, 0, 0);
    recv("b2b_a1", 32, 0, 0);
    recv("b2b_a2", 50, 0, 0);
    check("b2b_s_ready", int'(s_ready), 1);
    send_set(set4, 0);
    recv("b2b_b0", 5, 0, 0);
    recv("b2b_b1", -6, 0, 0);
    recv("b2b_b2", 7, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mvm3_part1.md
Name: mvm3_part1

Overview:
Streaming 3x3 signed matrix-vector multiplier: y = A·x. Accepts 12 signed 8-bit words on a valid/ready slave port (A row-major, then x), emits three signed 16-bit results y[0..2] on a valid/ready master port, each with an overflow flag. Sits between an upstream word stream and a downstream consumer; one matrix/vector set is processed per pass, then the block returns to loading.

Parameters:
IN_W, 8, input element width (signed)
OUT_W, 16, output width (signed)
ACC_W, 18, internal accumulator width; must hold any exact 3-term sum of IN_W x IN_W products

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
s_valid  input  1  upstream data valid
s_ready  output  1  block can accept data_in this cycle
data_in  input  IN_W  signed input word; may be X when s_valid=0
m_valid  output  1  data_out/overflow valid
m_ready  input  1  downstream accepts output
data_out  output  OUT_W  signed result y[r]
overflow  output  1  y[r] exact value outside OUT_W signed range

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low.
- Reset: state=LOAD, load count=0, row=0, s_ready=0 during reset then 1 in LOAD, m_valid=0, data_out=0, overflow=0. Reset mid-operation discards all stored data and partial results.
- Transfer occurs on rising edge with valid&&ready on that port; data_in sampled only then (X tolerated otherwise).
- States: LOAD, COMPUTE, OUTPUT.
- LOAD: s_ready=1, m_valid=0. Accepted words 0..8 -> A[r][c] (index 3r+c), words 9..11 -> x[0..2]. Gaps in s_valid simply stall. Edge accepting word 11 -> COMPUTE, row=0; s_ready low from next cycle.
- COMPUTE: 3 cycles, k=0..2; acc (ACC_W, signed) cleared at row start, acc += A[row][k]*x[k] (full signed product, sign-extended). Third edge registers data_out = acc[OUT_W-1:0] (wrap) and overflow = (acc > 32767 or acc < -32768); m_valid=1; -> OUTPUT. So m_valid rises 3 edges after the accepting/handshake edge.
- Only the final sum is range-checked; intermediate excursions that return in range are not flagged.
- OUTPUT: m_valid=1; data_out and overflow held stable while m_ready=0. On m_valid&&m_ready: if row<2, row++ -> COMPUTE, m_valid=0 next cycle; if row==2 -> LOAD, count=0, s_ready=1 next cycle.
- s_ready never 1 outside LOAD; m_valid never 1 outside OUTPUT; no overlap of load and output.
- Stored A/x stay constant during COMPUTE/OUTPUT.

Optional Feature:
MVM3_SATURATE_EN: when defined, an out-of-range result drives data_out to 32767 (positive) or -32768 (negative); overflow still asserted. When undefined, data_out is the wrapped low OUT_W bits. Timing identical in both builds.

Decomposition:
- Package mvm3_pkg: IN_W/OUT_W/ACC_W constants, N=3, NUM_IN=12, state enum (LOAD, COMPUTE, OUTPUT), signed element/result typedefs.
- One sub-module natural: mvm3_mac (product + accumulate + clear, range check, optional saturation).

Test Plan:
- Inputs 1..9,1,2,3 with random s_valid/m_ready -> y = 14, 32, 50; overflow 0,0,0.
- Inputs 1,2,3,127,127,127,7,8,9,127,127,127 -> y0=762 ovf0; y1=-17149 ovf1 (48387 wrapped; 32767 with MVM3_SATURATE_EN); y2=3048 ovf0.
- All 12 inputs -128 -> each y=-16384 ovf1 (exact 49152; 32767 when saturating).
- m_ready held 0 for 20 cycles after m_valid -> data_out/overflow stable, s_ready stays 0; release -> single transfer.
- Reset (low) asserted after 7 accepted words, then full 1..9,1,2,3 set -> 14, 32, 50; no stale data.
- Two sets back-to-back (second: A=identity, x=5,-6,7) -> 14,32,50 then 5,-6,7; s_ready high the cycle after third output handshake.
